// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : ID-stage opcode decode and ID/EX, EX/MEM, MEM/WB control pipeline
//            with stall, flush, load-use hazard detection and sticky halt/err.
// Revision : 1.0
// ============================================================================
module pipe_ctrl_unit #(
    parameter int          REG_AW  = 3,
    parameter logic [31:0] OP_MASK = 32'hFFFF_FFFF,
    parameter bit          LU_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        opcode,
    input  logic              valid_ins,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_aluSrc,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_i1Fmt,
    output logic              ex_zeroExt,
    output logic              ex_regDst,
    output logic [4:0]        ex_aluOp,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_valid,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    output logic              wb_memToReg,
    output logic              wb_regWrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic              lu_stall,
    output logic              halt,
    output logic              err
);

    localparam logic [4:0] c_OP_NOP = 5'b00001;

    typedef struct packed {
        logic              valid;
        logic              aluSrc;
        logic              branch;
        logic              jump;
        logic              i1Fmt;
        logic              zeroExt;
        logic              regDst;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
        logic              regWrite;
        logic              haltTag;
        logic              errTag;
        logic [4:0]        aluOp;
        logic [REG_AW-1:0] rd;
    } idExT;

    typedef struct packed {
        logic              valid;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
        logic              regWrite;
        logic              haltTag;
        logic              errTag;
        logic [REG_AW-1:0] rd;
    } exMemT;

    typedef struct packed {
        logic              valid;
        logic              memToReg;
        logic              regWrite;
        logic              haltTag;
        logic              errTag;
        logic [REG_AW-1:0] rd;
    } memWbT;

    idExT  r_idEx;
    exMemT r_exMem;
    memWbT r_memWb;
    logic  r_halt;
    logic  r_err;

    idExT  w_dec;
    exMemT w_exMemNext;
    memWbT w_memWbNext;
    logic  w_luStall;
    logic  w_unsupported;

    // A real instruction whose opcode is masked off travels as a nop carrying
    // the err tag, so the error surfaces only if it survives to WB.
    assign w_unsupported = valid_ins & ~OP_MASK[opcode];

    always_comb begin
        w_dec       = '0;
        w_dec.valid = valid_ins;
        w_dec.rd    = valid_ins ? id_rd : '0;
        if (!valid_ins) begin
            w_dec.aluOp = c_OP_NOP;
        end else if (w_unsupported) begin
            w_dec.aluOp  = c_OP_NOP;
            w_dec.errTag = 1'b1;
        end else begin
            w_dec.aluOp = opcode;
            casez (opcode)
                5'b00000: w_dec.haltTag = 1'b1;
                5'b01000, 5'b01001: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.i1Fmt    = 1'b1;
                end
                5'b01010, 5'b01011: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.i1Fmt    = 1'b1;
                    w_dec.zeroExt  = 1'b1;
                end
                5'b101??: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.i1Fmt    = 1'b1;
                end
                5'b10000: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.i1Fmt    = 1'b1;
                    w_dec.memWrite = 1'b1;
                end
                5'b10001: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.i1Fmt    = 1'b1;
                    w_dec.memRead  = 1'b1;
                    w_dec.memToReg = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                5'b10011: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.i1Fmt    = 1'b1;
                    w_dec.memWrite = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                5'b11001, 5'b1101?, 5'b111??: begin
                    w_dec.regDst   = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                5'b11000: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                5'b10010: begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.zeroExt  = 1'b1;
                end
                5'b011??: begin
                    w_dec.aluSrc = 1'b1;
                    w_dec.branch = 1'b1;
                end
                5'b00100: w_dec.jump = 1'b1;
                5'b00101: begin
                    w_dec.jump   = 1'b1;
                    w_dec.aluSrc = 1'b1;
                end
                5'b00110: begin
                    w_dec.jump     = 1'b1;
                    w_dec.regWrite = 1'b1;
                end
                5'b00111: begin
                    w_dec.jump     = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.aluSrc   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    generate
        if (LU_EN) begin : g_luOn
            assign w_luStall = r_idEx.valid & r_idEx.memRead & valid_ins &
                               ((rs_used & (id_rs == r_idEx.rd)) |
                                (rt_used & (id_rt == r_idEx.rd)));
        end else begin : g_luOff
            assign w_luStall = 1'b0;
        end
    endgenerate

    always_comb begin
        w_exMemNext          = '0;
        w_exMemNext.valid    = r_idEx.valid;
        w_exMemNext.memRead  = r_idEx.memRead;
        w_exMemNext.memWrite = r_idEx.memWrite;
        w_exMemNext.memToReg = r_idEx.memToReg;
        w_exMemNext.regWrite = r_idEx.regWrite;
        w_exMemNext.haltTag  = r_idEx.haltTag;
        w_exMemNext.errTag   = r_idEx.errTag;
        w_exMemNext.rd       = r_idEx.rd;
    end

    always_comb begin
        w_memWbNext          = '0;
        w_memWbNext.valid    = r_exMem.valid;
        w_memWbNext.memToReg = r_exMem.memToReg;
        w_memWbNext.regWrite = r_exMem.regWrite;
        w_memWbNext.haltTag  = r_exMem.haltTag;
        w_memWbNext.errTag   = r_exMem.errTag;
        w_memWbNext.rd       = r_exMem.rd;
    end

    // Stall freezes everything; flush and load-use only bubble ID/EX while
    // the older entries keep draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idEx  <= '0;
            r_exMem <= '0;
            r_memWb <= '0;
            r_halt  <= 1'b0;
            r_err   <= 1'b0;
        end else if (!stall) begin
            r_idEx  <= (flush || w_luStall) ? '0 : w_dec;
            r_exMem <= w_exMemNext;
            r_memWb <= w_memWbNext;
            r_halt  <= r_halt | (w_memWbNext.valid & w_memWbNext.haltTag);
            r_err   <= r_err  | (w_memWbNext.valid & w_memWbNext.errTag);
        end
    end

    assign ex_valid     = r_idEx.valid;
    assign ex_aluSrc    = r_idEx.aluSrc;
    assign ex_branch    = r_idEx.branch;
    assign ex_jump      = r_idEx.jump;
    assign ex_i1Fmt     = r_idEx.i1Fmt;
    assign ex_zeroExt   = r_idEx.zeroExt;
    assign ex_regDst    = r_idEx.regDst;
    assign ex_aluOp     = r_idEx.aluOp;
    assign ex_rd        = r_idEx.rd;
    assign mem_valid    = r_exMem.valid;
    assign mem_memRead  = r_exMem.memRead;
    assign mem_memWrite = r_exMem.memWrite;
    assign mem_rd       = r_exMem.rd;
    assign wb_valid     = r_memWb.valid;
    assign wb_memToReg  = r_memWb.memToReg;
    assign wb_regWrite  = r_memWb.regWrite;
    assign wb_rd        = r_memWb.rd;
    assign lu_stall     = w_luStall;
    assign halt         = r_halt;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the single-cycle opcode decoder.
- Decodes the 5-bit opcode in ID and carries the resulting control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Adds per-stage valid bits, external stall, branch flush, load-use hazard detection, a configurable supported-opcode mask, and sticky halt/err reporting from WB.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
REG_AW, 3, register-address width of id_rd/id_rs/id_rt and the stage rd outputs
OP_MASK, 32'hFFFF_FFFF, bit i=1 means opcode i is supported; a valid unsupported opcode decodes as nop and flags err
LU_EN, 1, 1 enables load-use hazard detection; 0 forces lu_stall=0

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
opcode  in  5  ID-stage instruction[15:11]
valid_ins  in  1  ID holds a real instruction; 0 decodes as nop (opcode 00001)
id_rd  in  REG_AW  ID destination register (already selected by the datapath)
id_rs, id_rt  in  REG_AW  ID source registers
rs_used, rt_used  in  1  ID instruction reads rs / rt
stall  in  1  global freeze (memory busy)
flush  in  1  branch/jump resolved taken in EX; squash the ID instruction
ex_valid, ex_aluSrc, ex_branch, ex_jump, ex_i1Fmt, ex_zeroExt, ex_regDst  out  1 each  ID/EX bundle
ex_aluOp  out  5  ID/EX opcode
ex_rd, mem_rd, wb_rd  out  REG_AW  per-stage destination register
mem_valid, mem_memRead, mem_memWrite  out  1 each  EX/MEM bundle
wb_valid, wb_memToReg, wb_regWrite  out  1 each  MEM/WB bundle
lu_stall  out  1  combinational hold request to PC and IF/ID
halt  out  1  sticky halt-reached flag
err  out  1  sticky unsupported-opcode flag

Behaviour:
Decode (combinational, ID); unlisted signals are 0:
- 00000 halt: bundle halt tag only. 00001 nop, 00010 siic, 00011 rti: no controls.
- 01000, 01001: aluSrc, regWrite, i1Fmt. 01010, 01011: the same plus zeroExt.
- 101xx: aluSrc, regWrite, i1Fmt.
- 10000 st: aluSrc, i1Fmt, memWrite.
- 10001 ld: aluSrc, i1Fmt, memRead, memToReg, regWrite.
- 10011 stu: aluSrc, i1Fmt, memWrite, regWrite.
- 11001, 1101x, 111xx: regDst, regWrite.
- 11000 lbi: aluSrc, regWrite. 10010 slbi: aluSrc, regWrite, zeroExt.
- 011xx: aluSrc, branch.
- 00100: jump. 00101: jump, aluSrc. 00110: jump, regWrite. 00111: jump, regWrite, aluSrc.
- valid_ins=1 with OP_MASK[opcode]=0: bundle decodes as nop and carries an err tag.

Pipeline registers (posedge clk):
- Each stage holds a valid bit, control fields, rd, a halt tag and an err tag.
- A bubble is all-zero with valid=0.
- rst=1: every stage becomes a bubble; halt=0; err=0. rst overrides stall and flush.
- Priority on each clock: stall, then flush, then lu_stall.
  - stall=1: all three stages hold. flush and lu_stall have no effect that cycle.
  - flush=1: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - lu_stall=1: ID/EX loads a bubble; downstream stages advance. The ID instruction is retained externally and re-decoded next cycle.
  - Otherwise: ID/EX <- decode; EX/MEM <- ID/EX; MEM/WB <- EX/MEM.
- Latency: an ID instruction reaches EX outputs 1 cycle later, MEM at 2, WB at 3 (no stalls).

lu_stall (LU_EN=1):
- lu_stall = ex_valid & ex_memRead & valid_ins & ((rs_used & id_rs==ex_rd) | (rt_used & id_rt==ex_rd)).
- ex_memRead is the internal ID/EX memRead bit.
- Register 0 is not special-cased.

halt and err:
- halt sets on the clock where MEM/WB loads a valid entry with the halt tag. It remains 1 until rst.
- err follows the same rule using the err tag.
- Entries behind a halt keep flowing; the front-end is responsible for stopping fetch.
- A halt or err instruction squashed by flush or bubbled never sets its flag.

Test Plan:
- Reset with stall=1 and flush=1 held high -> all valids 0, halt=0, err=0, lu_stall=0.
- ld (10001, rd=3) then add (11011, rs=3, rs_used=1) -> lu_stall=1 for exactly 1 cycle; ex_valid=0 the next cycle; add reaches WB 4 cycles after ID, with wb_regWrite=1 and wb_rd=3.
- addi (01000, rd=2) with flush=1 in its ID cycle -> ex_valid=0 next cycle; wb_regWrite stays 0 for 3 cycles.
- stall=1 for 2 cycles while st (10000) is in ID/EX -> ex_* unchanged for 2 cycles; mem_memWrite=1 one cycle after stall drops.
- OP_MASK=32'hFFFF_FFFB with siic (00010) valid_ins=1 -> err=1 exactly 3 cycles later and sticky; a second run with valid_ins=0 -> err stays 0.
- halt (00000) followed by nops -> halt=1 from the 3rd clock after ID and stays 1 until rst=1.
